// File: rtl/mux_stim_sequencer.sv
// mux_stim_sequencer: stimulus and check stage for the 3-input logic block
// (y = a&b | a&~c). Walks {a,b,c} through all 8 vectors, either timed (auto) or
// one debounced button press per vector (manual). Each sampled y_in is compared
// against GOLDEN. The results are reported as a per-vector error mask, an error
// count and a pass flag.
// Optional feature: define MUX_STIM_DEBOUNCE_EN to add the step-button
// debouncer. Without it, the step pulse is the rising edge of the synchronized
// button.
module mux_stim_sequencer #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned DB_CYCLES   = 8,
    parameter logic [7:0]  GOLDEN      = 8'hD0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       auto_en,
    input  logic       step_btn,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       vec_valid,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [7:0] err_mask
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [3:0]      err_cnt_q, err_cnt_d;
    logic [7:0]      err_mask_q, err_mask_d;
    logic            mode_q, mode_d;
    logic [2:0]      abc_q, abc_d;
    logic            vec_valid_q, done_q, pass_q;
    logic            pass_d;
    logic            advance;

    logic [1:0]      sync_q;
    logic            step_pulse;

    // Two-flop synchronizer for the raw push-button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], step_btn};
        end
    end

`ifdef MUX_STIM_DEBOUNCE_EN
    localparam int unsigned DbW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DbW-1:0] DbLast = DbW'(DB_CYCLES - 1);

    logic           db_level_q;
    logic [DbW-1:0] db_cnt_q;
    logic           step_pulse_q;

    // Debouncer: the level follows the synchronized input only after it has
    // differed for DB_CYCLES consecutive cycles; a rising toggle emits one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level_q   <= 1'b0;
            db_cnt_q     <= '0;
            step_pulse_q <= 1'b0;
        end else if (sync_q[1] == db_level_q) begin
            db_cnt_q     <= '0;
            step_pulse_q <= 1'b0;
        end else if (db_cnt_q == DbLast) begin
            db_level_q   <= ~db_level_q;
            db_cnt_q     <= '0;
            step_pulse_q <= ~db_level_q;
        end else begin
            db_cnt_q     <= db_cnt_q + 1'b1;
            step_pulse_q <= 1'b0;
        end
    end

    assign step_pulse = step_pulse_q;
`else
    logic sync_prev_q;

    // Delayed copy of the synchronized button for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_prev_q <= 1'b0;
        end else begin
            sync_prev_q <= sync_q[1];
        end
    end

    assign step_pulse = sync_q[1] & ~sync_prev_q;
`endif

    // Next-state logic: run control, vector advance and result compare.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        err_cnt_d  = err_cnt_q;
        err_mask_d = err_mask_q;
        mode_d     = mode_q;
        advance    = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StRun;
                    idx_d      = 3'd0;
                    hold_d     = '0;
                    err_cnt_d  = 4'd0;
                    err_mask_d = 8'h00;
                    mode_d     = auto_en;
                end
            end
            StRun: begin
                if (mode_q) begin
                    if (hold_q == HoldLast) begin
                        advance = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end else begin
                    advance = step_pulse;
                end

                if (advance) begin
                    if (y_in != GOLDEN[idx_q]) begin
                        err_mask_d[idx_q] = 1'b1;
                        err_cnt_d         = err_cnt_q + 4'd1;
                    end
                    // idx stays at 7 on the final sample; the wrap happens via DONE.
                    if (idx_q == 3'd7) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from next-state values so every output leaves a flop.
    always_comb begin
        abc_d  = (state_d == StRun) ? idx_d : 3'b000;
        pass_d = (state_d == StDone) && (err_cnt_d == 4'd0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= 3'd0;
            hold_q      <= '0;
            err_cnt_q   <= 4'd0;
            err_mask_q  <= 8'h00;
            mode_q      <= 1'b0;
            abc_q       <= 3'b000;
            vec_valid_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            err_cnt_q   <= err_cnt_d;
            err_mask_q  <= err_mask_d;
            mode_q      <= mode_d;
            abc_q       <= abc_d;
            vec_valid_q <= (state_d == StRun);
            done_q      <= (state_d == StDone);
            pass_q      <= pass_d;
        end
    end

    assign {a, b, c}  = abc_q;
    assign vec_valid  = vec_valid_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign err_mask   = err_mask_q;

endmodule

// File: tb/tb_mux_stim_sequencer.sv
// Testbench for mux_stim_sequencer: auto runs against a correct, stuck-at-0 and
// inverted logic-block model, manual stepping, button bounce, ignored events
// and asynchronous reset. Expected vectors are queued when a run is launched and
// popped as the DUT presents each vector.
module tb_mux_stim_sequencer;

    localparam int unsigned HOLD = 4;
    localparam int unsigned DB   = 8;
`ifdef MUX_STIM_DEBOUNCE_EN
    localparam int LAT        = DB + 3;
    localparam int BOUNCE_ADV = 1;
`else
    localparam int LAT        = 3;
    localparam int BOUNCE_ADV = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       auto_en = 1'b1;
    logic       step_btn = 1'b0;
    logic       y_in;
    logic       a, b, c;
    logic       vec_valid, done, pass;
    logic [3:0] err_cnt;
    logic [7:0] err_mask;

    int         y_mode = 0;  // 0 correct, 1 stuck at 0, 2 inverted
    int         n_pass = 0;
    int         n_total = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    mux_stim_sequencer #(
        .HOLD_CYCLES(HOLD),
        .DB_CYCLES  (DB),
        .GOLDEN     (8'hD0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .auto_en  (auto_en),
        .step_btn (step_btn),
        .y_in     (y_in),
        .a        (a),
        .b        (b),
        .c        (c),
        .vec_valid(vec_valid),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .err_mask (err_mask)
    );

    function automatic logic logic_fn(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & ~v[0]);
    endfunction

    function automatic logic model_y(input int mode, input logic [2:0] v);
        if (mode == 0) return logic_fn(v);
        if (mode == 1) return 1'b0;
        return ~logic_fn(v);
    endfunction

    always_comb y_in = model_y(y_mode, {a, b, c});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({a, b, c, vec_valid, done, pass} !== 6'b0) begin
            $display("FAIL reset_ctrl: got %b expected 000000", {a, b, c, vec_valid, done, pass});
        end else n_pass++;
        n_total++;
        if ({err_cnt, err_mask} !== 12'h000) begin
            $display("FAIL reset_err: got %h expected 000", {err_cnt, err_mask});
        end else n_pass++;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_total++;
        if (done !== 1'b0 || vec_valid !== 1'b0) begin
            $display("FAIL idle_after_reset: got done=%b vv=%b expected 0 0", done, vec_valid);
        end else n_pass++;
    endtask

    // Launch an auto run and check every cycle of it; optionally inject events
    // that must be ignored (start in RUN, auto_en changes, button presses).
    task automatic do_auto_run(input int ym, input bit noisy, input string tag);
        logic [7:0] exp_mask = 8'h00;
        logic [3:0] exp_cnt  = 4'd0;
        logic [2:0] cur = 3'd0;
        y_mode = ym;
        for (int i = 0; i < 8; i++) begin
            if (model_y(ym, 3'(i)) != logic_fn(3'(i))) begin
                exp_mask[i] = 1'b1;
                exp_cnt     = exp_cnt + 4'd1;
            end
        end
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
        auto_en = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8 * HOLD; k++) begin
            if (noisy) begin
                if (k == 2) step_btn = 1'b1;
                if (k == 5) start = 1'b1;
                if (k == 6) start = 1'b0;
                if (k == 10) auto_en = 1'b0;
                if (k == 18) step_btn = 1'b0;
                if (k == 20) auto_en = 1'b1;
            end
            if (k % HOLD == 0) cur = exp_q.pop_front();
            n_total++;
            if ({a, b, c} !== cur || vec_valid !== 1'b1 || done !== 1'b0) begin
                $display("FAIL %s_vec k=%0d: got abc=%0d vv=%b done=%b expected abc=%0d vv=1 done=0",
                         tag, k, {a, b, c}, vec_valid, done, cur);
            end else n_pass++;
            if (k == 0) begin
                n_total++;
                if (err_cnt !== 4'd0 || err_mask !== 8'h00 || pass !== 1'b0) begin
                    $display("FAIL %s_clear: got cnt=%0d mask=%h pass=%b expected 0 00 0",
                             tag, err_cnt, err_mask, pass);
                end else n_pass++;
            end
            tick();
        end
        n_total++;
        if (done !== 1'b1 || vec_valid !== 1'b0 || {a, b, c} !== 3'b000) begin
            $display("FAIL %s_done: got done=%b vv=%b abc=%0d expected 1 0 0",
                     tag, done, vec_valid, {a, b, c});
        end else n_pass++;
        n_total++;
        if (err_cnt !== exp_cnt || err_mask !== exp_mask || pass !== (exp_cnt == 4'd0)) begin
            $display("FAIL %s_result: got cnt=%0d mask=%h pass=%b expected cnt=%0d mask=%h pass=%b",
                     tag, err_cnt, err_mask, pass, exp_cnt, exp_mask, exp_cnt == 4'd0);
        end else n_pass++;
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_sb_left: got %0d expected 0", tag, exp_q.size());
        end else n_pass++;
        repeat (15) tick();
        n_total++;
        if (done !== 1'b1 || err_cnt !== exp_cnt) begin
            $display("FAIL %s_hold: got done=%b cnt=%0d expected 1 %0d", tag, done, err_cnt, exp_cnt);
        end else n_pass++;
    endtask

    task automatic test_auto_pass();
        do_auto_run(0, 1'b0, "auto_pass");
    endtask

    task automatic test_auto_fail();
        do_auto_run(1, 1'b0, "auto_fail");
        do_auto_run(0, 1'b0, "restart");
    endtask

    task automatic test_ignored();
        do_auto_run(0, 1'b1, "ignored");
    endtask

    task automatic test_manual();
        logic [2:0] cur = 3'd0;
        y_mode  = 0;
        exp_q.delete();
        for (int i = 1; i < 8; i++) exp_q.push_back(3'(i));
        auto_en = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        auto_en = 1'b1;
        n_total++;
        if ({a, b, c} !== 3'd0 || vec_valid !== 1'b1) begin
            $display("FAIL man_start: got abc=%0d vv=%b expected 0 1", {a, b, c}, vec_valid);
        end else n_pass++;
        for (int p = 0; p < 8; p++) begin
            step_btn = 1'b1;
            for (int e = 1; e <= 20; e++) begin
                tick();
                if (e == LAT - 1) begin
                    n_total++;
                    if ({a, b, c} !== cur || done !== 1'b0) begin
                        $display("FAIL man_early p=%0d: got abc=%0d done=%b expected %0d 0",
                                 p, {a, b, c}, done, cur);
                    end else n_pass++;
                end
                if (e == LAT) begin
                    if (p < 7) begin
                        cur = exp_q.pop_front();
                        n_total++;
                        if ({a, b, c} !== cur) begin
                            $display("FAIL man_step p=%0d: got abc=%0d expected %0d", p, {a, b, c}, cur);
                        end else n_pass++;
                    end else begin
                        n_total++;
                        if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 4'd0) begin
                            $display("FAIL man_done: got done=%b pass=%b cnt=%0d expected 1 1 0",
                                     done, pass, err_cnt);
                        end else n_pass++;
                    end
                end
            end
            step_btn = 1'b0;
            repeat (20) tick();
        end
        // A press in DONE must not restart or move anything.
        step_btn = 1'b1;
        repeat (20) tick();
        step_btn = 1'b0;
        repeat (20) tick();
        n_total++;
        if (done !== 1'b1 || {a, b, c} !== 3'd0 || vec_valid !== 1'b0) begin
            $display("FAIL man_done_press: got done=%b abc=%0d vv=%b expected 1 0 0",
                     done, {a, b, c}, vec_valid);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        auto_en = 1'b1;
        y_mode  = 2;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (3 * HOLD + 1) tick();
        n_total++;
        if ({a, b, c} !== 3'd3 || err_cnt !== 4'd3) begin
            $display("FAIL mid_pre: got abc=%0d cnt=%0d expected 3 3", {a, b, c}, err_cnt);
        end else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({a, b, c, vec_valid, done, pass} !== 6'b0 || err_cnt !== 4'd0 || err_mask !== 8'h00) begin
            $display("FAIL mid_async_reset: got ctrl=%b cnt=%0d mask=%h expected 0 0 00",
                     {a, b, c, vec_valid, done, pass}, err_cnt, err_mask);
        end else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        do_auto_run(0, 1'b0, "after_reset");
    endtask

    task automatic test_bounce();
        y_mode  = 0;
        auto_en = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        auto_en = 1'b1;
        step_btn = 1'b1; repeat (2) tick();
        step_btn = 1'b0; repeat (2) tick();
        step_btn = 1'b1; repeat (2) tick();
        repeat (20) tick();
        step_btn = 1'b0;
        repeat (20) tick();
        n_total++;
        if ({a, b, c} !== 3'(BOUNCE_ADV) || vec_valid !== 1'b1) begin
            $display("FAIL bounce: got abc=%0d vv=%b expected %0d 1", {a, b, c}, vec_valid, BOUNCE_ADV);
        end else n_pass++;
    endtask

    initial begin
        #2;
        test_reset();
        test_auto_pass();
        test_auto_fail();
        test_ignored();
        test_manual();
        test_reset_mid_run();
        test_bounce();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
